// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Bundle of the functional-unit request side and the Common Data Bus
//   broadcast side of the CDB arbiter.
//   master : the functional units / environment (drives requests, sees grants
//            and the broadcast).
//   slave  : the arbiter itself.
//   Signals:
//     requireCDB  per-unit request, bit i = unit i holds a finished result
//     reqTag      per-unit tag, unit i at [i*TAG_W +: TAG_W]
//     reqData     per-unit data, unit i at [i*DATA_W +: DATA_W]
//     stall       suppresses all grants while high
//     resultAC    one-hot (or zero) combinational grant
//     cdbValid    registered broadcast valid
//     cdbTag      registered broadcast tag
//     cdbData     registered broadcast data
interface cdb_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        requireCDB;
  logic [NREQ*TAG_W-1:0]  reqTag;
  logic [NREQ*DATA_W-1:0] reqData;
  logic                   stall;
  logic [NREQ-1:0]        resultAC;
  logic                   cdbValid;
  logic [TAG_W-1:0]       cdbTag;
  logic [DATA_W-1:0]      cdbData;

  modport master (
    output requireCDB, reqTag, reqData, stall,
    input  resultAC, cdbValid, cdbTag, cdbData
  );

  modport slave (
    input  requireCDB, reqTag, reqData, stall,
    output resultAC, cdbValid, cdbTag, cdbData
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter and broadcaster for the Common Data Bus. A grant is
//   issued combinationally in the cycle a unit requests; the winner's tag and
//   data are registered and broadcast on the CDB in the following cycle.
//   Ports:
//     clk   system clock, rising edge
//     nRST  asynchronous active-low reset
//     bus   cdb_arbiter_if slave: requests/tags/data/stall in,
//           resultAC grant and cdbValid/cdbTag/cdbData broadcast out
module cdb_arbiter #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        nRST,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [PTR_W:0]   NREQ_X = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(NREQ - 1);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [NREQ-1:0]   grant_vec;

  // cand_idx[k] is the unit that sits k places after ptr in priority order,
  // i.e. (ptr + k) mod NREQ, computed without a divider.
  logic [PTR_W-1:0]  cand_idx [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [PTR_W:0] sum;
      assign sum          = {1'b0, ptr_q} + (PTR_W+1)'(gi);
      assign cand_idx[gi] = (sum >= NREQ_X) ? PTR_W'(sum - NREQ_X) : sum[PTR_W-1:0];
    end
  endgenerate

  // Scan from the lowest priority upward so the highest-priority requester
  // is the last one written and therefore wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (nRST && !bus.stall) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (bus.requireCDB[cand_idx[k]]) begin
          grant_any = 1'b1;
          grant_idx = cand_idx[k];
        end
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  assign bus.resultAC = grant_vec;

  // Broadcast registers are cleared on idle cycles so the bus never carries
  // stale tags alongside a low valid.
  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = '0;
    cdb_data_d  = '0;
    if (grant_any) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = bus.reqTag[grant_idx*TAG_W +: TAG_W];
      cdb_data_d  = bus.reqData[grant_idx*DATA_W +: DATA_W];
      ptr_d       = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign bus.cdbValid = cdb_valid_q;
  assign bus.cdbTag   = cdb_tag_q;
  assign bus.cdbData  = cdb_data_q;

endmodule
